// File: rtl/prga_if.sv
// prga_if: bundles the RC4 PRGA engine's start/idle handshake and its three
// memory buses (S read/write, CT read-only, PT write-only).
//   en, rdy                       start request / idle-and-ready handshake
//   s_addr, s_wrdata, s_wren,     S-box memory address, write data, write
//   s_rddata                      enable, and synchronous read data
//   ct_addr, ct_rddata            ciphertext memory address and read data
//   pt_addr, pt_wrdata, pt_wren   plaintext memory address, data, enable
// slave  : the engine side (prga).
// master : the environment side (controller plus memories).
interface prga_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  modport slave (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  modport master (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/prga.sv
// prga: RC4 pseudo-random generation and decrypt engine. Continues the RC4
// i/j walk over the S-box left behind by the key schedule, XORs each
// keystream byte with a length-prefixed ciphertext from CT memory and writes
// the length-prefixed plaintext to PT memory.
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset; also gates write enables and rdy
//   bus    prga_if.slave: en/rdy handshake plus S, CT and PT memory buses
// All memories are single-port with a one-cycle synchronous read, so every
// read is an address cycle followed by a data cycle.
module prga (
  input  logic   clk,
  input  logic   rst_n,
  prga_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LEN_RD = 4'd1,
    LEN_WR = 4'd2,
    RD_SI  = 4'd3,
    RD_SJ  = 4'd4,
    WR_SI  = 4'd5,
    WR_SJ  = 4'd6,
    RD_PAD = 4'd7,
    WR_PT  = 4'd8
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [7:0] i_r,   i_nxt_s;
  logic [7:0] j_r,   j_nxt_s;
  logic [7:0] k_r,   k_nxt_s;
  logic [7:0] len_r, len_nxt_s;
  logic [7:0] si_r,  si_nxt_s;
  logic [7:0] sj_r,  sj_nxt_s;
  logic [7:0] ctb_r, ctb_nxt_s;

  logic       rdy_s;
  logic [7:0] s_addr_s;
  logic [7:0] s_wrdata_s;
  logic       s_wren_s;
  logic [7:0] ct_addr_s;
  logic [7:0] pt_addr_s;
  logic [7:0] pt_wrdata_s;
  logic       pt_wren_s;
  logic [7:0] j_sum_s;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      i_r     <= 8'h00;
      j_r     <= 8'h00;
      k_r     <= 8'h00;
      len_r   <= 8'h00;
      si_r    <= 8'h00;
      sj_r    <= 8'h00;
      ctb_r   <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      i_r     <= i_nxt_s;
      j_r     <= j_nxt_s;
      k_r     <= k_nxt_s;
      len_r   <= len_nxt_s;
      si_r    <= si_nxt_s;
      sj_r    <= sj_nxt_s;
      ctb_r   <= ctb_nxt_s;
    end
  end

  // New j is needed both as the next register value and as this cycle's
  // S address, so compute it once (mod-256 wrap is the 8-bit truncation).
  assign j_sum_s = j_r + bus.s_rddata;

  // Next-state logic and per-state memory bus drive.
  always_comb begin
    state_nxt_s = state_r;
    i_nxt_s     = i_r;
    j_nxt_s     = j_r;
    k_nxt_s     = k_r;
    len_nxt_s   = len_r;
    si_nxt_s    = si_r;
    sj_nxt_s    = sj_r;
    ctb_nxt_s   = ctb_r;
    rdy_s       = 1'b0;
    s_addr_s    = 8'h00;
    s_wrdata_s  = 8'h00;
    s_wren_s    = 1'b0;
    ct_addr_s   = 8'h00;
    pt_addr_s   = 8'h00;
    pt_wrdata_s = 8'h00;
    pt_wren_s   = 1'b0;

    case (state_r)
      IDLE: begin
        rdy_s = 1'b1;
        if (bus.en) begin
          i_nxt_s     = 8'h00;
          j_nxt_s     = 8'h00;
          state_nxt_s = LEN_RD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LEN_RD: begin
        ct_addr_s   = 8'h00;
        state_nxt_s = LEN_WR;
      end
      LEN_WR: begin
        // The length byte is copied straight through as the PT prefix.
        pt_addr_s   = 8'h00;
        pt_wrdata_s = bus.ct_rddata;
        pt_wren_s   = 1'b1;
        len_nxt_s   = bus.ct_rddata;
        if (bus.ct_rddata == 8'h00) begin
          state_nxt_s = IDLE;
        end else begin
          k_nxt_s     = 8'h01;
          i_nxt_s     = i_r + 8'h01;
          state_nxt_s = RD_SI;
        end
      end
      RD_SI: begin
        s_addr_s    = i_r;
        state_nxt_s = RD_SJ;
      end
      RD_SJ: begin
        si_nxt_s    = bus.s_rddata;
        j_nxt_s     = j_sum_s;
        s_addr_s    = j_sum_s;
        state_nxt_s = WR_SI;
      end
      WR_SI: begin
        // When i==j both swap writes carry the same value, so no special case.
        sj_nxt_s    = bus.s_rddata;
        s_addr_s    = i_r;
        s_wrdata_s  = bus.s_rddata;
        s_wren_s    = 1'b1;
        state_nxt_s = WR_SJ;
      end
      WR_SJ: begin
        // CT fetch overlaps the second swap write.
        s_addr_s    = j_r;
        s_wrdata_s  = si_r;
        s_wren_s    = 1'b1;
        ct_addr_s   = k_r;
        state_nxt_s = RD_PAD;
      end
      RD_PAD: begin
        s_addr_s    = si_r + sj_r;
        ctb_nxt_s   = bus.ct_rddata;
        state_nxt_s = WR_PT;
      end
      WR_PT: begin
        pt_addr_s   = k_r;
        pt_wrdata_s = bus.s_rddata ^ ctb_r;
        pt_wren_s   = 1'b1;
        // Compare before incrementing so L=255 ends without k overflowing.
        if (k_r == len_r) begin
          state_nxt_s = IDLE;
        end else begin
          k_nxt_s     = k_r + 8'h01;
          i_nxt_s     = i_r + 8'h01;
          state_nxt_s = RD_SI;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Reset aborts at once: enables and rdy are gated by rst_n itself so no
  // write lands at the reset edge.
  assign bus.rdy       = rdy_s & rst_n;
  assign bus.s_wren    = s_wren_s & rst_n;
  assign bus.pt_wren   = pt_wren_s & rst_n;
  assign bus.s_addr    = s_addr_s;
  assign bus.s_wrdata  = s_wrdata_s;
  assign bus.ct_addr   = ct_addr_s;
  assign bus.pt_addr   = pt_addr_s;
  assign bus.pt_wrdata = pt_wrdata_s;

endmodule

// File: tb/tb_prga.sv
// tb_prga: self-checking bench for prga. Models the S, CT and PT memories,
// keeps an independent RC4-PRGA reference (plain array arithmetic) that
// predicts every PT write into a scoreboard queue, and a monitor that pops
// and compares on each pt_wren. Also times rdy-low periods and compares the
// final S-box against the reference.
module tb_prga;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prga_if bus ();

  prga dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0]  s_mem  [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  pt_mem [256];
  logic [7:0]  ms     [256];
  logic [15:0] exp_q  [$];
  int          checks = 0;
  int          failures = 0;
  int          s_wr_cnt = 0;

  // Memory models: registered read, write at the edge where wren=1.
  always @(posedge clk) begin
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.ct_rddata <= ct_mem[bus.ct_addr];
    if (bus.s_wren) s_mem[bus.s_addr] = bus.s_wrdata;
    if (bus.pt_wren) pt_mem[bus.pt_addr] = bus.pt_wrdata;
  end

  // Monitor: every PT write must match the next predicted write.
  always @(negedge clk) begin
    logic [15:0] e;
    if (bus.s_wren) s_wr_cnt++;
    if (bus.pt_wren) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pt_unexpected: got addr=%0d data=%02h, required no write",
                 bus.pt_addr, bus.pt_wrdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.pt_addr, bus.pt_wrdata} !== e) begin
          failures++;
          $display("FAIL pt_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   bus.pt_addr, bus.pt_wrdata, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic load_identity();
    for (int x = 0; x < 256; x++) begin
      s_mem[x] = x[7:0];
      ms[x]    = x[7:0];
    end
  endtask

  // Reference RC4-PRGA over the model S-box; predicts all PT writes.
  task automatic model_run(input int len);
    int i;
    int j;
    logic [7:0] t;
    logic [7:0] pad;
    i = 0;
    j = 0;
    exp_q.push_back({8'h00, len[7:0]});
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + ms[i]) % 256;
      t = ms[i];
      ms[i] = ms[j];
      ms[j] = t;
      pad = ms[(ms[i] + ms[j]) % 256];
      exp_q.push_back({k[7:0], pad ^ ct_mem[k]});
    end
  endtask

  // Pulse en for one cycle and count cycles with rdy low afterwards.
  task automatic start_and_time(output int cnt);
    @(posedge clk); #1 bus.en = 1'b1;
    @(posedge clk); #1 bus.en = 1'b0;
    cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.rdy) break;
      cnt++;
    end
  endtask

  task automatic finish_op(input string name);
    int bad;
    repeat (2) @(negedge clk);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ms[x]) bad++;
    check({name, "_s_final_mismatches"}, bad, 0);
  endtask

  initial begin
    int cnt;
    int len;
    logic [7:0] trace;

    bus.en = 1'b0;
    for (int x = 0; x < 256; x++) begin
      ct_mem[x] = 8'h00;
      pt_mem[x] = 8'hAA;
    end
    load_identity();

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rdy", bus.rdy, 0);
    check("reset_s_wren", bus.s_wren, 0);
    check("reset_pt_wren", bus.pt_wren, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_reset", bus.rdy, 1);

    // One byte, identity S: i=j=1 swap is a no-op, pad S[2]=2.
    ct_mem[0] = 8'd1; ct_mem[1] = 8'h41;
    model_run(1);
    s_wr_cnt = 0;
    start_and_time(cnt);
    check("l1_rdy_low", cnt, 8);
    finish_op("l1");
    check("l1_pt0", pt_mem[0], 8'd1);
    check("l1_pt1", pt_mem[1], 8'h43);
    check("l1_s_wren_count", s_wr_cnt, 2);

    // Two bytes, identity S.
    load_identity();
    ct_mem[0] = 8'd2; ct_mem[1] = 8'h41; ct_mem[2] = 8'h00;
    model_run(2);
    start_and_time(cnt);
    check("l2_rdy_low", cnt, 14);
    finish_op("l2");
    check("l2_pt1", pt_mem[1], 8'h43);
    check("l2_pt2", pt_mem[2], 8'h05);
    check("l2_s2", s_mem[2], 8'd3);
    check("l2_s3", s_mem[3], 8'd2);

    // Zero length with en held high: two back-to-back 2-cycle runs.
    ct_mem[0] = 8'd0; pt_mem[0] = 8'hAA;
    model_run(0);
    model_run(0);
    s_wr_cnt = 0;
    @(posedge clk); #1 bus.en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      trace[n] = bus.rdy;
      @(posedge clk); #1;
      if (n == 3) bus.en = 1'b0;
    end
    check("l0_rdy_trace", trace, 8'b11001001);
    check("l0_s_wren_count", s_wr_cnt, 0);
    check("l0_pt0", pt_mem[0], 8'd0);
    finish_op("l0");

    // Full-length message, identity S, random ciphertext.
    load_identity();
    ct_mem[0] = 8'd255;
    for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom_range(0, 255));
    model_run(255);
    start_and_time(cnt);
    check("l255_rdy_low", cnt, 1532);
    finish_op("l255");

    // Random messages chained on the S-box left behind.
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 40);
      ct_mem[0] = len[7:0];
      for (int x = 1; x <= len; x++) ct_mem[x] = 8'($urandom_range(0, 255));
      model_run(len);
      start_and_time(cnt);
      check("rand_rdy_low", cnt, 2 + 6 * len);
      finish_op("rand");
    end

    // Reset asserted during WR_SI of byte 1.
    load_identity();
    ct_mem[0] = 8'd1; ct_mem[1] = 8'h41; pt_mem[1] = 8'hAA;
    exp_q.push_back(16'h0001);
    @(posedge clk); #1 bus.en = 1'b1;
    @(posedge clk); #1 bus.en = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_s_wren", bus.s_wren, 0);
    check("abort_pt_wren", bus.pt_wren, 0);
    check("abort_rdy", bus.rdy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_rdy_after", bus.rdy, 1);
    check("abort_pt1_untouched", pt_mem[1], 8'hAA);
    finish_op("abort");
    model_run(1);
    start_and_time(cnt);
    check("after_abort_rdy_low", cnt, 8);
    finish_op("after_abort");
    check("after_abort_pt1", pt_mem[1], 8'h43);

    // en toggling every cycle during a 2-byte run: exactly one operation.
    load_identity();
    ct_mem[0] = 8'd2; ct_mem[1] = 8'h41; ct_mem[2] = 8'h00;
    pt_mem[1] = 8'hAA; pt_mem[2] = 8'hAA;
    model_run(2);
    s_wr_cnt = 0;
    @(posedge clk); #1 bus.en = 1'b1;
    @(posedge clk); #1 bus.en = ~bus.en;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.rdy) break;
      cnt++;
      @(posedge clk); #1 bus.en = ~bus.en;
    end
    bus.en = 1'b0;
    check("toggle_rdy_low", cnt, 14);
    repeat (3) @(negedge clk);
    check("toggle_still_idle", bus.rdy, 1);
    check("toggle_s_wren_count", s_wr_cnt, 4);
    check("toggle_pt1", pt_mem[1], 8'h43);
    check("toggle_pt2", pt_mem[2], 8'h05);
    check("toggle_s2", s_mem[2], 8'd3);
    check("toggle_s3", s_mem[3], 8'd2);
    finish_op("toggle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prga.md
Name: prga

Overview:
- RC4 pseudo-random generation and decrypt engine. It is the consumer of the permuted S-box that ksa leaves in the shared S memory.
- Once started, it reads a length-prefixed ciphertext from CT memory and continues the RC4 i/j walk over S, swapping entries as it goes.
- It writes the length-prefixed plaintext (keystream XOR ciphertext) to PT memory.
- It uses the same en/rdy handshake as ksa, so the top level can chain ksa rdy into prga en.

Parameters:
(none; all widths fixed at 8-bit data, 8-bit address, 256-entry memories)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  start request, sampled only while rdy=1
rdy  out  1  high when idle and able to accept en
s_addr  out  8  S memory address
s_rddata  in  8  S memory read data, valid the cycle after s_addr presented
s_wrdata  out  8  S memory write data
s_wren  out  1  S memory write enable
ct_addr  out  8  CT memory address (read-only)
ct_rddata  in  8  CT read data, valid the cycle after ct_addr presented
pt_addr  out  8  PT memory address
pt_wrdata  out  8  PT write data
pt_wren  out  1  PT write enable

Behaviour:
- Memories are single-port with synchronous read: the address is registered at the edge and rddata is valid throughout the following cycle. A write occurs at the edge where wren=1.
- Memory addresses and data are combinational functions of state and internal registers. Internal registers are i, j, k, len, si, sj and ctb, all 8-bit.
- All arithmetic is mod 256 (8-bit wrap, carries discarded).
- Reset, while rst_n=0 at an edge: state<=IDLE, and i, j, k, len, si, sj, ctb<=0.
  - s_wren, pt_wren and rdy are forced 0 combinationally while rst_n=0.
  - rdy=1 the first cycle rst_n=1.
- Reset mid-operation: aborts immediately. No further writes occur, and S/PT contents are left as-is.
- FSM states and per-cycle actions:
  - IDLE: rdy=1, all wren=0. If en=1 at an edge: i<=0, j<=0, goto LEN_RD. Otherwise stay.
  - LEN_RD: ct_addr=0. Goto LEN_WR.
  - LEN_WR: pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1, len<=ct_rddata.
    - If ct_rddata==0: goto IDLE.
    - Else: k<=1, i<=i+1, goto RD_SI.
  - RD_SI: s_addr=i. Goto RD_SJ.
  - RD_SJ: si<=s_rddata, j<=j+s_rddata, s_addr=j+s_rddata. Goto WR_SI.
  - WR_SI: sj<=s_rddata, s_addr=i, s_wrdata=s_rddata, s_wren=1. Goto WR_SJ.
  - WR_SJ: s_addr=j, s_wrdata=si, s_wren=1, ct_addr=k. Goto RD_PAD.
  - RD_PAD: s_addr=si+sj, ctb<=ct_rddata. Goto WR_PT.
  - WR_PT: pt_addr=k, pt_wrdata=s_rddata XOR ctb, pt_wren=1.
    - If k==len: goto IDLE.
    - Else: k<=k+1, i<=i+1, goto RD_SI.
- rdy is 1 only in IDLE. en in any other state is ignored, and a held-high en does not cause a restart until rdy has returned to 1.
- Latency: after the edge that accepts en, rdy is 0 for exactly 2+6*L cycles (L = ct[0]). Then it returns to 1.
- i==j: the two swap writes hit the same address with the same value. The result is correct and needs no special case.
- Length L=255: k counts 1..255 with no overflow. i and j wrap freely past 255.
- Each message runs on the S state the previous operation left behind. prga never reinitialises S; the ksa block owns that.

Test Plan:
- S preloaded identity (S[x]=x), ct={1,0x41}, pulse en 1 cycle -> pt[0]=1, pt[1]=0x43 (pad=S[2]=2, i=j=1 no-op swap); rdy low 8 cycles; S unchanged.
- Identity S, ct={2,0x41,0x00} -> pt={2,0x43,0x05}; S[2]=3, S[3]=2, all other S[x]=x; rdy low 14 cycles.
- ct={0} -> pt[0]=0, no s_wren pulse ever, rdy low exactly 2 cycles; en held high afterwards restarts only once rdy=1 is observed.
- Identity S, ct[0]=255, random ct[1..255] -> pt matches software RC4-PRGA model byte-for-byte (j wraps past 255); rdy low 1532 cycles; final S equals model.
- rst_n driven 0 for 1 cycle during WR_SI of byte 1 -> s_wren/pt_wren 0 that cycle, rdy=1 next cycle; fresh run with identity S and ct={1,0x41} gives pt[1]=0x43 (i, j restarted at 0).
- en toggled every cycle during a 2-byte run -> exactly one operation, final pt/S identical to scenario 2.
